// File: rtl/pipe_gen_pkg.sv
// Shared types and helpers for the scrolling pipe field generator.
package pipe_pkg;

  typedef logic [15:0][15:0] pixmap_t;
  typedef logic [15:0]       col_t;

  typedef enum logic [1:0] {
    WAIT   = 2'd0,
    RUN    = 2'd1,
    FROZEN = 2'd2
  } state_t;

  // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic col_t gap_col(input logic [3:0] gapTop, input int gapH);
    col_t c;
    c = '1;
    for (int r = 0; r < 16; r++) begin
      if ((r >= int'(gapTop)) && (r < int'(gapTop) + gapH)) c[r] = 1'b0;
    end
    return c;
  endfunction

endpackage

// File: rtl/pipe_gen_lfsr16.sv
// 16-bit Fibonacci LFSR that advances one step per adv pulse.
module lfsr16
  import pipe_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        adv,
  output logic [15:0] q
);

  always_ff @(posedge clk) begin
    if (reset)    q <= SEED;
    else if (adv) q <= {q[14:0], ^(q & LFSR_TAPS)};
  end

endmodule

// File: rtl/pipe_gen.sv
// Scrolling green pipe field with scoring; PIPE_GEN_SPEEDUP_EN shortens the
// step period by one clock for every 8 points.
module pipe_gen
  import pipe_pkg::*;
#(
  parameter int          TICK_DIV     = 8,
  parameter int          PIPE_SPACING = 6,
  parameter int          GAP_H        = 4,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              isDead,
  output logic [15:0][15:0] GrnPixels,
  output logic [7:0]        score,
  output logic              pipe_passed
);

  state_t      state;
  logic [7:0]  tickCnt;
  logic [7:0]  termCnt;
  logic [3:0]  spaceCnt;
  logic [15:0] lfsrQ;
  logic        runTick;
  logic        step;
  logic        inject;
  col_t        newCol;
  col_t        dropCol;
  logic        unusedLfsrHi;

  function automatic logic [7:0] satInc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Keep the gap fully inside the 16 rows
  function automatic logic [3:0] clampGap(input logic [3:0] raw);
    if (int'(raw) > 16 - GAP_H) return 4'(int'(raw) - GAP_H);
    return raw;
  endfunction

`ifdef PIPE_GEN_SPEEDUP_EN
  function automatic logic [7:0] speedTerm(input logic [4:0] level);
    int period;
    period = TICK_DIV - int'(level);
    if (period < 2) period = 2;
    return 8'(period - 1);
  endfunction

  assign termCnt = speedTerm(score[7:3]);
`else
  assign termCnt = 8'(TICK_DIV - 1);
`endif

  assign runTick = (state == RUN) && !isDead;
  assign step    = runTick && (tickCnt == termCnt);
  assign inject  = step && (spaceCnt == 4'd0);

  always_comb begin
    newCol  = '0;
    dropCol = '0;
    if (spaceCnt == 4'd0) newCol = gap_col(clampGap(lfsrQ[3:0]), GAP_H);
    for (int r = 0; r < 16; r++) dropCol[r] = GrnPixels[r][15];
  end

  lfsr16 #(.SEED(LFSR_SEED)) uLfsr (
    .clk   (clk),
    .reset (reset),
    .adv   (inject),
    .q     (lfsrQ)
  );

  assign unusedLfsrHi = ^lfsrQ[15:4];

  // Step stage: shift, inject and score all land on the same edge
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= WAIT;
      tickCnt     <= 8'd0;
      spaceCnt    <= 4'd0;
      GrnPixels   <= '0;
      score       <= 8'd0;
      pipe_passed <= 1'b0;
    end else begin
      pipe_passed <= 1'b0;
      case (state)
        WAIT: if (start) state <= RUN;
        RUN: begin
          if (isDead) begin
            state <= FROZEN;
          end else begin
            // A period shrink can leave tickCnt past the new terminal: wrap silently
            tickCnt <= (tickCnt >= termCnt) ? 8'd0 : tickCnt + 8'd1;
            if (step) begin
              for (int r = 0; r < 16; r++) GrnPixels[r] <= {GrnPixels[r][14:0], newCol[r]};
              spaceCnt <= inject ? 4'(PIPE_SPACING - 1) : spaceCnt - 4'd1;
              if (|dropCol) begin
                score       <= satInc(score);
                pipe_passed <= 1'b1;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_gen.sv
// Self-checking bench for pipe_gen: directed vector table, multi-cycle corner
// sequences and randomized stimulus against a step-level reference model.
module tb_pipe_gen;
  localparam int          TD   = 2;
  localparam int          PS   = 3;
  localparam int          GH   = 4;
  localparam logic [15:0] SEED = 16'hACE1;

  logic              clk = 1'b0;
  logic              reset = 1'b1, start = 1'b0, isDead = 1'b0;
  logic [15:0][15:0] GrnPixels;
  logic [7:0]        score;
  logic              pipe_passed;

  int nChecks = 0;
  int nFails  = 0;

  always #5 clk = ~clk;

  pipe_gen #(.TICK_DIV(TD), .PIPE_SPACING(PS), .GAP_H(GH), .LFSR_SEED(SEED)) dut (
    .clk(clk), .reset(reset), .start(start), .isDead(isDead),
    .GrnPixels(GrnPixels), .score(score), .pipe_passed(pipe_passed)
  );

`ifdef PIPE_GEN_SPEEDUP_EN
  logic              fReset = 1'b1, fStart = 1'b0, fDead = 1'b0;
  logic [15:0][15:0] fPix;
  logic [7:0]        fScore;
  logic              fPass;
  pipe_gen #(.TICK_DIV(4), .PIPE_SPACING(PS), .GAP_H(GH), .LFSR_SEED(SEED)) dutFast (
    .clk(clk), .reset(fReset), .start(fStart), .isDead(fDead),
    .GrnPixels(fPix), .score(fScore), .pipe_passed(fPass)
  );
`endif

  // Reference model: field as 16 column words, steps counted in whole periods
  int          mState;   // 0 wait, 1 run, 2 frozen
  int          mClk;
  int          mSteps;
  int          mScore;
  bit          mPass;
  logic [15:0] mLfsr;
  logic [15:0] mCols [16];

  function automatic logic [15:0] lfsrNext(input logic [15:0] v);
    return {v[14:0], v[16-1] ^ v[14-1] ^ v[13-1] ^ v[11-1]};
  endfunction

  function automatic logic [15:0] gapWord(input logic [15:0] v);
    int top;
    top = int'(v[3:0]);
    if (top > 16 - GH) top = top - GH;
    return ~(16'((1 << GH) - 1) << top);
  endfunction

  task automatic doStep();
    logic [15:0] dropped;
    dropped = mCols[15];
    for (int c = 15; c > 0; c--) mCols[c] = mCols[c-1];
    if (mSteps % PS == 0) begin
      mCols[0] = gapWord(mLfsr);
      mLfsr    = lfsrNext(mLfsr);
    end else begin
      mCols[0] = 16'h0;
    end
    mSteps++;
    if (dropped != 16'h0) begin
      if (mScore < 255) mScore++;
      mPass = 1'b1;
    end
  endtask

  task automatic modelStep();
    mPass = 1'b0;
    if (reset) begin
      mState = 0; mClk = 0; mSteps = 0; mScore = 0; mLfsr = SEED;
      for (int c = 0; c < 16; c++) mCols[c] = 16'h0;
    end else if (mState == 0) begin
      if (start) begin mState = 1; mClk = 0; mSteps = 0; end
    end else if (mState == 1) begin
      if (isDead) mState = 2;
      else begin
        mClk++;
        if (mClk % TD == 0) doStep();
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    modelStep();
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] colWord(input logic [15:0][15:0] pm, input int c);
    logic [15:0] w;
    for (int r = 0; r < 16; r++) w[r] = pm[r][c];
    return w;
  endfunction

  task automatic checkModel(input string tag);
    logic [15:0][15:0] exp;
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) exp[r][c] = mCols[c][r];
    chk({tag, ".pix"}, GrnPixels, exp);
    chk({tag, ".score"}, 256'(score), 256'(mScore));
    chk({tag, ".pass"}, 256'(pipe_passed), 256'(mPass));
  endtask

  task automatic pulseStart();
    start = 1'b1; cyc(); start = 1'b0;
  endtask

  typedef struct {
    int          stepNo;
    int          col;
    logic [15:0] word;
    int          sc;
  } vec_t;
  vec_t vt [9];

  int satPulses;
  int seen, gapC;
  logic [255:0] prevPix;

  initial begin
    vt[0] = '{1, 0, 16'hFFE1, 0};
    vt[1] = '{1, 1, 16'h0000, 0};
    vt[2] = '{4, 3, 16'hFFE1, 0};
    vt[3] = '{4, 0, 16'hFF87, 0};
    vt[4] = '{7, 0, 16'hF87F, 0};
    vt[5] = '{10, 0, 16'h87FF, 0};
    vt[6] = '{16, 15, 16'hFFE1, 0};
    vt[7] = '{17, 13, 16'hFF87, 1};
    vt[8] = '{17, 15, 16'h0000, 1};

    // Reset state and idle WAIT
    reset = 1'b1; cyc(); reset = 1'b0;
    chk("reset.pix", GrnPixels, '0);
    chk("reset.score", 256'(score), 0);
    chk("reset.pass", 256'(pipe_passed), 0);
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("wait.pix", GrnPixels, '0);
      checkModel("wait");
    end

    // Directed scroll, checked against the vector table at each step
    pulseStart();
    for (int s = 1; s <= 17; s++) begin
      for (int k = 0; k < TD; k++) begin
        cyc();
        checkModel("run");
      end
      for (int v = 0; v < 9; v++) begin
        if (vt[v].stepNo == s) begin
          chk($sformatf("vec%0d.col%0d", v, vt[v].col), 256'(colWord(GrnPixels, vt[v].col)), 256'(vt[v].word));
          chk($sformatf("vec%0d.score", v), 256'(score), 256'(vt[v].sc));
        end
      end
      if (s == 16) chk("pass.before", 256'(pipe_passed), 0);
      if (s == 17) chk("pass.pulse", 256'(pipe_passed), 1);
    end
    cyc();
    chk("pass.after", 256'(pipe_passed), 0);

    // Freeze mid-run; start pulses must not disturb anything
    isDead = 1'b1; cyc(); isDead = 1'b0;
    for (int i = 0; i < 40; i++) begin
      start = i[0];
      cyc();
      checkModel("frozen");
    end
    start = 1'b0;
    chk("frozen.col13", 256'(colWord(GrnPixels, 13)), 256'(16'hFF87));
    chk("frozen.score", 256'(score), 1);

    // Reset out of FROZEN, then resume
    reset = 1'b1; cyc(); reset = 1'b0;
    chk("rstFrozen.pix", GrnPixels, '0);
    chk("rstFrozen.score", 256'(score), 0);
    pulseStart(); cyc(); cyc();
    chk("resume.col0", 256'(colWord(GrnPixels, 0)), 256'(16'hFFE1));
    checkModel("resume");

    // isDead on the very edge that would have been the first step
    reset = 1'b1; cyc(); reset = 1'b0;
    pulseStart(); cyc();
    isDead = 1'b1; cyc(); isDead = 1'b0;
    chk("deadOnStep.pix", GrnPixels, '0);
    for (int i = 0; i < 10; i++) cyc();
    chk("deadOnStep.hold", GrnPixels, '0);
    checkModel("deadOnStep");

    // Long run to score saturation
    reset = 1'b1; cyc(); reset = 1'b0;
    pulseStart();
    satPulses = 0;
    for (int i = 0; i < 1800; i++) begin
      cyc();
      checkModel("sat");
      if (score == 8'hFF && pipe_passed) satPulses++;
    end
    chk("sat.score", 256'(score), 255);
    chk("sat.pulses", 256'(satPulses > 0), 1);

    // Randomized control inputs
    for (int i = 0; i < 2000; i++) begin
      reset  = ($urandom_range(0, 299) == 0);
      start  = ($urandom_range(0, 9) == 0);
      isDead = ($urandom_range(0, 149) == 0);
      cyc();
      checkModel("rand");
    end
    reset = 1'b0; start = 1'b0; isDead = 1'b0;

`ifdef PIPE_GEN_SPEEDUP_EN
    // TICK_DIV=4 with score >= 16 must step every 2 clocks
    fReset = 1'b1; cyc(); fReset = 1'b0;
    fStart = 1'b1; cyc(); fStart = 1'b0;
    for (int i = 0; i < 4000 && fScore < 8'd16; i++) cyc();
    chk("speed.reach16", 256'(fScore >= 8'd16), 1);
    seen = 0; gapC = 0; prevPix = fPix;
    for (int i = 0; i < 40 && seen < 5; i++) begin
      cyc();
      gapC++;
      if (fPix !== prevPix) begin
        if (seen > 0) chk("speed.period", 256'(gapC), 2);
        seen++;
        gapC = 0;
        prevPix = fPix;
      end
    end
    chk("speed.steps", 256'(seen), 5);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
